lut_interp: RTL
===============

LUT_INTERP -- requirements
Module: lut_interp

Interface
REQ-001 Parameter XW, default 24: width of the abscissa field and of in_x; must be at least 2.
REQ-002 Parameter YW, default 24: width of the ordinate field and of out_y; must be at least 2.
REQ-003 Parameter DEPTH, default 128: number of table entries; must be at least 2; AW = clog2(DEPTH).
REQ-004 Parameter MODE, default 0: 0 selects linear scan, 1 selects binary search.
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 in_valid  in  1  a query is present on in_x.
REQ-008 in_ready  out  1  block accepts a query; high only in IDLE.
REQ-009 in_x  in  XW  query abscissa, unsigned.
REQ-010 rom_addr  out  AW  table read address.
REQ-011 rom_data  in  XW+YW  asynchronous table read {X[rom_addr], Y[rom_addr]}, valid in the same cycle; X is unsigned and strictly increasing, Y is unsigned.
REQ-012 out_valid  out  1  result is valid.
REQ-013 out_ready  in  1  consumer takes the result.
REQ-014 out_y  out  YW  interpolated ordinate.
REQ-015 out_sat  out  1  query was outside the range [X[0], X[DEPTH-1]] and the result was clamped.

Function
REQ-016 States: IDLE, SEARCH, CALC, DONE; only these four.
REQ-017 IDLE: in_ready=1, rom_addr=0; when in_valid=1 at a clock edge, the block captures in_x and enters SEARCH.
REQ-018 MODE 0, SEARCH: rom_addr starts at 0 and increments by 1 each cycle. Each entry with X<=x is registered as the lower point (x0,y0). The first entry with X>x is registered as the upper point (x1,y1). This ends the search, as does reaching addr=DEPTH-1.
REQ-019 MODE 1, SEARCH, probe order:
- probe 0; if X[0]>x, low clamp;
- then probe DEPTH-1; if X[DEPTH-1]<=x, high case;
- otherwise set lo=0, hi=DEPTH-1 and probe mid=(lo+hi)>>1 until hi-lo=1.
- Each probe with X<=x sets lo=mid and the lower point; otherwise it sets hi=mid and the upper point.
REQ-020 SEARCH cycles S:
- MODE 0: S = j+1, where j is the first index with X[j]>x, else S = DEPTH.
- MODE 1: S <= 2+ceil(log2(DEPTH-1)), except S=1 on low clamp and S=2 on high case.
REQ-021 CALC lasts one cycle. out_valid rises on the clock edge ending CALC, which is exactly S+2 edges after the accepting edge.
REQ-022 Interior result: out_y = y0 + trunc0(((x-x0)*(y1-y0))/(x1-x0)).
- (y1-y0) is signed, YW+1 bits.
- The product is signed, XW+YW+1 bits.
- Division truncates toward zero; division is combinational within CALC.
- Result lies between y0 and y1, so no overflow is possible; out_sat=0.
REQ-023 Exact hit: x equal to any table X[i] yields out_y=Y[i] and out_sat=0, including x=X[DEPTH-1].
REQ-024 Clamps: x<X[0] gives out_y=Y[0] and out_sat=1; x>X[DEPTH-1] gives out_y=Y[DEPTH-1] and out_sat=1.
REQ-025 DONE: out_valid=1; out_y and out_sat are held stable until out_ready=1 at an edge, then the block returns to IDLE. No new query is accepted while in DONE.
REQ-026 in_valid and in_x are ignored outside IDLE. rom_data is sampled only in SEARCH.
REQ-027 out_y and out_sat keep their last values after the handshake, until the next CALC.

Reset
REQ-028 reset=1 forces IDLE immediately, in any state including mid-SEARCH or DONE.
REQ-029 Reset values: out_valid=0, out_y=0, out_sat=0, rom_addr=0, in_ready=1 (IDLE); all internal point, index and capture registers are cleared to 0.
REQ-030 A query in flight when reset asserts is discarded; no output is produced for it.

Verification
Table for all scenarios: DEPTH=4, X={100,200,300,400}, Y={1000,2000,1500,1500}, XW=YW=24, out_ready=1 unless stated.
REQ-031 MODE 0, x=250 -> rom_addr sequence 0,1,2; out_y=1750; out_sat=0; out_valid 5 edges after accept.
REQ-032 MODE 0, x=50 -> S=1, out_y=1000, out_sat=1; x=450 -> S=4, out_y=1500, out_sat=1; x=400 -> out_y=1500, out_sat=0; x=200 -> out_y=2000, out_sat=0.
REQ-033 MODE 1, same queries as REQ-031 and REQ-032 -> identical out_y and out_sat; x=250 probes 0,3,1,2.
REQ-034 out_ready held low 3 cycles after out_valid -> out_valid and out_y (1750) stable, in_ready=0; release -> IDLE the next edge, in_ready=1.
REQ-035 reset pulsed during SEARCH for x=250 -> out_valid=0, out_y=0, rom_addr=0, in_ready=1 immediately; a following query x=300 -> out_y=1500.

Source files
------------

// File: rtl/lut_interp_if.sv
// Query, table-read and result signals of lut_interp.
interface lut_interp_if #(
    parameter int XW = 24,
    parameter int YW = 24,
    parameter int AW = 7
);
    logic             in_valid;
    logic             in_ready;
    logic [XW-1:0]    in_x;
    logic [AW-1:0]    rom_addr;
    logic [XW+YW-1:0] rom_data;
    logic             out_valid;
    logic             out_ready;
    logic [YW-1:0]    out_y;
    logic             out_sat;

    modport slave (
        input  in_valid, in_x, rom_data, out_ready,
        output in_ready, rom_addr, out_valid, out_y, out_sat
    );

    modport master (
        output in_valid, in_x, rom_data, out_ready,
        input  in_ready, rom_addr, out_valid, out_y, out_sat
    );
endinterface

// File: rtl/lut_interp.sv
// Piecewise-linear lookup: finds the segment of a sorted external table that
// brackets the query abscissa and interpolates the ordinate, clamping outside.
module lut_interp #(
    parameter int XW    = 24,
    parameter int YW    = 24,
    parameter int DEPTH = 128,
    parameter int MODE  = 0
) (
    input logic         clk,
    input logic         reset,
    lut_interp_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = XW + YW + 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        CALC   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t        state_r, state_next_s;
    logic [XW-1:0] x_r, x0_r, x1_r;
    logic [YW-1:0] y0_r, y1_r;
    logic          have_lo_r, have_hi_r;
    logic [AW-1:0] addr_r, lo_r, hi_r;
    logic [1:0]    phase_r;
    logic          drain_r;
    logic          out_valid_r, out_sat_r;
    logic [YW-1:0] out_y_r;

    logic [XW-1:0] rom_x_s;
    logic [YW-1:0] rom_y_s;
    logic          le_s;
    logic [AW-1:0] next_addr_s, next_lo_s, next_hi_s;
    logic [1:0]    next_phase_s;
    logic          probe_end_s;
    logic [AW:0]   mid_sum_s;

    logic signed [YW:0]   dy_s;
    logic signed [PW-1:0] num_s, den_s, quo_s;
    logic [YW-1:0]        y_res_s;
    logic                 sat_res_s;

    assign rom_x_s = bus.rom_data[XW+YW-1:YW];
    assign rom_y_s = bus.rom_data[YW-1:0];
    assign le_s    = (rom_x_s <= x_r);

    assign bus.in_ready  = (state_r == IDLE);
    assign bus.rom_addr  = addr_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_y     = out_y_r;
    assign bus.out_sat   = out_sat_r;

    // Next probe address and bisection bounds from the entry on rom_data.
    always_comb begin
        next_addr_s  = addr_r;
        next_lo_s    = lo_r;
        next_hi_s    = hi_r;
        next_phase_s = phase_r;
        probe_end_s  = 1'b0;
        mid_sum_s    = {(AW+1){1'b0}};
        if (MODE == 0) begin
            if (!le_s || addr_r == LAST) begin
                probe_end_s = 1'b1;
            end else begin
                next_addr_s = addr_r + AW'(1'b1);
            end
        end else begin
            // Phase 0 probes entry 0, phase 1 the last entry, phase 2 bisects.
            case (phase_r)
                2'd0: begin
                    if (!le_s) begin
                        probe_end_s = 1'b1;
                    end else begin
                        next_addr_s  = LAST;
                        next_phase_s = 2'd1;
                    end
                end
                2'd1: begin
                    if (le_s) begin
                        probe_end_s = 1'b1;
                    end else begin
                        next_lo_s    = {AW{1'b0}};
                        next_hi_s    = LAST;
                        next_phase_s = 2'd2;
                    end
                end
                default: begin
                    if (le_s) begin
                        next_lo_s = addr_r;
                    end else begin
                        next_hi_s = addr_r;
                    end
                end
            endcase
            if (next_phase_s == 2'd2 && !probe_end_s) begin
                mid_sum_s = {1'b0, next_lo_s} + {1'b0, next_hi_s};
                if (next_hi_s - next_lo_s == AW'(1'b1)) begin
                    probe_end_s = 1'b1;
                end else begin
                    next_addr_s = AW'(mid_sum_s >> 1);
                end
            end else begin
                mid_sum_s = {(AW+1){1'b0}};
            end
        end
    end

    // Interpolation and clamp selection from the captured bracket points.
    always_comb begin
        dy_s  = $signed({1'b0, y1_r}) - $signed({1'b0, y0_r});
        num_s = PW'($signed({1'b0, x_r - x0_r})) * PW'(dy_s);
        if (have_lo_r && have_hi_r) begin
            den_s = PW'($signed({1'b0, x1_r - x0_r}));
        end else begin
            den_s = PW'(2'sb01);
        end
        quo_s = num_s / den_s;
        if (!have_lo_r) begin
            y_res_s   = y1_r;
            sat_res_s = 1'b1;
        end else if (!have_hi_r) begin
            y_res_s   = y0_r;
            sat_res_s = (x_r != x0_r);
        end else begin
            y_res_s   = YW'(y0_r + quo_s);
            sat_res_s = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode; the final probe settles during one drain cycle.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) state_next_s = SEARCH;
                else              state_next_s = IDLE;
            end
            SEARCH: begin
                if (drain_r) state_next_s = CALC;
                else         state_next_s = SEARCH;
            end
            CALC: state_next_s = DONE;
            DONE: begin
                if (bus.out_ready) state_next_s = IDLE;
                else               state_next_s = DONE;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Capture, search and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_r         <= {XW{1'b0}};
            x0_r        <= {XW{1'b0}};
            x1_r        <= {XW{1'b0}};
            y0_r        <= {YW{1'b0}};
            y1_r        <= {YW{1'b0}};
            have_lo_r   <= 1'b0;
            have_hi_r   <= 1'b0;
            addr_r      <= {AW{1'b0}};
            lo_r        <= {AW{1'b0}};
            hi_r        <= {AW{1'b0}};
            phase_r     <= 2'd0;
            drain_r     <= 1'b0;
            out_valid_r <= 1'b0;
            out_sat_r   <= 1'b0;
            out_y_r     <= {YW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        x_r       <= bus.in_x;
                        have_lo_r <= 1'b0;
                        have_hi_r <= 1'b0;
                        addr_r    <= {AW{1'b0}};
                        lo_r      <= {AW{1'b0}};
                        hi_r      <= {AW{1'b0}};
                        phase_r   <= 2'd0;
                        drain_r   <= 1'b0;
                    end
                end
                SEARCH: begin
                    if (!drain_r) begin
                        if (le_s) begin
                            x0_r      <= rom_x_s;
                            y0_r      <= rom_y_s;
                            have_lo_r <= 1'b1;
                        end else begin
                            x1_r      <= rom_x_s;
                            y1_r      <= rom_y_s;
                            have_hi_r <= 1'b1;
                        end
                        addr_r  <= next_addr_s;
                        lo_r    <= next_lo_s;
                        hi_r    <= next_hi_s;
                        phase_r <= next_phase_s;
                        drain_r <= probe_end_s;
                    end
                end
                CALC: begin
                    out_y_r     <= y_res_s;
                    out_sat_r   <= sat_res_s;
                    out_valid_r <= 1'b1;
                    addr_r      <= {AW{1'b0}};
                    drain_r     <= 1'b0;
                end
                DONE: begin
                    if (bus.out_ready) out_valid_r <= 1'b0;
                end
                default: begin
                    addr_r <= {AW{1'b0}};
                end
            endcase
        end
    end
endmodule
